sprite_compositor: RTL and testbench
====================================

Name: sprite_compositor

Overview:
- Pixel-path stage directly downstream of the sprite renderers (coin, penguin, obstacles).
- Takes each sprite's colour and hit flag plus the background colour, and picks the top layer by fixed priority.
- Drives registered RGB and data-enable to the video output encoder.
- Consumes the coin renderer's level-type `scored` flag and turns it into a saturating score count. Also reports a per-frame player/coin pixel-collision flag.

Parameters:
- NUM_LAYERS, 4, number of sprite layers; layer 0 has highest priority; layer 0 = player, layer 1 = coin.
- SCORE_WIDTH, 16, width of the score counter.

Ports:
- i_clk  in  1  pixel clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_de  in  1  active-video data enable, aligned with sprite outputs.
- i_v_sync  in  1  vertical sync, same timing as the sync fed to the sprite renderers.
- i_hit  in  NUM_LAYERS  per-layer opaque-pixel hit; bit k = layer k.
- i_rgb  in  24*NUM_LAYERS  per-layer colour; layer k at [24k+23:24k], ordered R[23:16], G[15:8], B[7:0].
- i_bg_rgb  in  24  background colour, same ordering.
- i_scored  in  1  level flag from the coin renderer; high while the coin is in the scoring zone.
- i_score_clr  in  1  synchronous score clear (game restart).
- o_red  out  8  composited red.
- o_green  out  8  composited green.
- o_blue  out  8  composited blue.
- o_de  out  1  data enable, delayed to match RGB.
- o_score  out  SCORE_WIDTH  current score.
- o_score_pulse  out  1  one-cycle strobe on each score increment.
- o_collision  out  1  player/coin pixel overlap seen during the previous frame.

Behaviour:
- Reset (i_rst=1 at a clock edge): all outputs 0; all pipeline, edge-detect and pending registers 0; score_armed=1.
- Pixel pipeline has a fixed latency of 2 cycles; i_hit/i_rgb/i_bg_rgb/i_de at edge n appear on o_* after edge n+2.
- Stage 1: registers the colour of the lowest-index layer k with i_hit[k]=1; if none, registers i_bg_rgb. Also registers i_de.
- Stage 2: output register. RGB is forced to 0x000000 when the stage-2 de is 0; o_de follows the stage-2 de.
- i_hit bits are only trusted when i_de=1. Hits with i_de=0 are ignored for colour, collision and everything else; i_rgb of unhit layers is don't-care and must never reach the output.
- Frame start: frame_start = i_v_sync & ~vs_q, where vs_q is i_v_sync registered.
- Collision:
  - pending is set on any cycle with i_de & i_hit[0] & i_hit[1].
  - At frame_start, o_collision <= pending (or the same-cycle overlap), and pending clears.
  - If set and clear coincide, the set wins: pending stays 1.
  - o_collision holds its value for a whole frame.
- Score:
  - scored_rise = i_scored & ~scored_q.
  - Increment when scored_rise & score_armed. In that cycle o_score <= o_score+1, saturating at 2^SCORE_WIDTH-1; o_score_pulse=1 for exactly 1 cycle; score_armed <= 0.
  - At saturation o_score is held, but o_score_pulse still fires.
  - score_armed <= 1 at frame_start, giving at most one increment per frame.
  - If an increment and frame_start coincide: the increment happens and score_armed ends at 0.
  - A level held high across many frames counts once; it needs a falling then a rising edge.
- i_score_clr: o_score <= 0, o_score_pulse <= 0, score_armed <= 1. It overrides a same-cycle increment. It does not affect the pixel pipeline or collision.
- Reset mid-frame: the pipeline flushes to zero. The first valid output appears 2 cycles after the first i_de=1 following reset release.
- Datapath is purely registered. No combinational path from any input to any output.

Test Plan:
- Priority: de=1, hits=4'b0110, layer1=FFDB00, layer2=00FF00, bg=000080 -> two cycles later RGB=FF,DB,00, o_de=1. Then hits=0 -> RGB=00,00,80.
- Blanking: de=0, hits=4'b1111 -> RGB=0, o_de=0 two cycles later; pending stays 0 and o_collision=0 after the next frame_start.
- Collision: one pixel with hit[0]&hit[1]&de in frame N -> o_collision=1 after frame N+1's v_sync rise. No overlap in frame N+1 -> o_collision=0 after frame N+2's rise.
- Score:
  - i_scored high for 300 cycles -> o_score 0->1, one o_score_pulse.
  - Second rise in the same frame -> no increment.
  - Rise after the next frame_start -> o_score=2.
- Saturation/clear:
  - SCORE_WIDTH=4, 16 armed rises -> o_score=15, 16th pulse present.
  - i_score_clr together with scored_rise -> o_score=0, no pulse.
- Reset mid-stream: i_rst during active video -> all outputs 0 on the next edge; the pipeline refills with latency 2.

Source files
------------

// File: rtl/sprite_compositor.sv
// Sprite compositor: picks the top sprite layer by fixed priority over the background,
// registers RGB/DE with 2-cycle latency, and tracks per-frame collision and a saturating score.
module sprite_compositor #(
   parameter int NUM_LAYERS  = 4,
   parameter int SCORE_WIDTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_de,
   input  logic                     i_v_sync,
   input  logic [NUM_LAYERS-1:0]    i_hit,
   input  logic [24*NUM_LAYERS-1:0] i_rgb,
   input  logic [23:0]              i_bg_rgb,
   input  logic                     i_scored,
   input  logic                     i_score_clr,
   output logic [7:0]               o_red,
   output logic [7:0]               o_green,
   output logic [7:0]               o_blue,
   output logic                     o_de,
   output logic [SCORE_WIDTH-1:0]   o_score,
   output logic                     o_score_pulse,
   output logic                     o_collision
);

   logic [23:0] w_pix;
   logic        w_found;
   logic        w_frame_start;
   logic        w_overlap;
   logic        w_scored_rise;
   logic        w_inc;

   logic [23:0] r_s1_rgb;
   logic        r_s1_de;
   logic        r_vs_q;
   logic        r_scored_q;
   logic        r_pending;
   logic        r_armed;

   // Hits are only trusted during active video; unhit layer colours never get selected.
   always_comb begin
      w_pix   = i_bg_rgb;
      w_found = 1'b0;
      for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
         if (!w_found && i_de && i_hit[k]) begin
            w_pix   = i_rgb[24*k +: 24];
            w_found = 1'b1;
         end
      end
   end

   assign w_frame_start = i_v_sync & ~r_vs_q;
   assign w_overlap     = i_de & i_hit[0] & i_hit[1];
   assign w_scored_rise = i_scored & ~r_scored_q;
   assign w_inc         = w_scored_rise & r_armed;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1_rgb <= '0;
         r_s1_de  <= 1'b0;
         o_de     <= 1'b0;
         o_red    <= '0;
         o_green  <= '0;
         o_blue   <= '0;
      end else begin
         r_s1_rgb <= w_pix;
         r_s1_de  <= i_de;
         o_de     <= r_s1_de;
         {o_red, o_green, o_blue} <= r_s1_de ? r_s1_rgb : '0;
      end
   end

   // A same-cycle overlap at frame start is reported and also kept pending (set wins).
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_vs_q      <= 1'b0;
         r_pending   <= 1'b0;
         o_collision <= 1'b0;
      end else begin
         r_vs_q <= i_v_sync;
         if (w_frame_start) begin
            o_collision <= r_pending | w_overlap;
            r_pending   <= w_overlap;
         end else begin
            r_pending <= r_pending | w_overlap;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_scored_q    <= 1'b0;
         r_armed       <= 1'b1;
         o_score       <= '0;
         o_score_pulse <= 1'b0;
      end else begin
         r_scored_q <= i_scored;
         if (i_score_clr) begin
            o_score       <= '0;
            o_score_pulse <= 1'b0;
            r_armed       <= 1'b1;
         end else begin
            o_score_pulse <= w_inc;
            if (w_inc) begin
               r_armed <= 1'b0;
               if (o_score != '1)
                  o_score <= o_score + SCORE_WIDTH'(1);
            end else if (w_frame_start) begin
               r_armed <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed literal checks followed by randomized frames,
// all compared every cycle against a frame-level behavioural model.
module tb_sprite_compositor;
   localparam int NL = 4;
   localparam int SW = 4;

   logic             clk = 1'b0;
   logic             rst, de, vs, scored, clr;
   logic [NL-1:0]    hit;
   logic [24*NL-1:0] rgb;
   logic [23:0]      bg;
   logic [7:0]       o_red, o_green, o_blue;
   logic             o_de, o_score_pulse, o_collision;
   logic [SW-1:0]    o_score;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sprite_compositor #(.NUM_LAYERS(NL), .SCORE_WIDTH(SW)) dut (
      .i_clk(clk), .i_rst(rst), .i_de(de), .i_v_sync(vs), .i_hit(hit), .i_rgb(rgb),
      .i_bg_rgb(bg), .i_scored(scored), .i_score_clr(clr),
      .o_red(o_red), .o_green(o_green), .o_blue(o_blue), .o_de(o_de),
      .o_score(o_score), .o_score_pulse(o_score_pulse), .o_collision(o_collision)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: pixel history, frame-level collision memory, per-frame score allowance.
   logic        m_valid = 1'b0;
   logic [24:0] m_s1, m_out;
   logic        m_prev_vs, m_prev_sc, m_seen, m_coll, m_pulse, m_may_score;
   int          m_score;

   always @(posedge clk) begin
      logic [23:0] pix;
      logic fs, ov, rise;
      if (rst) begin
         m_valid = 1'b1; m_s1 = '0; m_out = '0; m_prev_vs = 0; m_prev_sc = 0;
         m_seen = 0; m_coll = 0; m_pulse = 0; m_may_score = 1; m_score = 0;
      end else begin
         fs   = vs && !m_prev_vs;
         ov   = de && hit[0] && hit[1];
         rise = scored && !m_prev_sc;
         m_out = m_s1;
         pix = bg;
         for (int k = NL - 1; k >= 0; k--)
            if (de && hit[k]) pix = rgb[24*k +: 24];
         m_s1 = de ? {1'b1, pix} : 25'h0;
         if (fs) begin
            m_coll = m_seen || ov;
            m_seen = ov;
         end else begin
            m_seen = m_seen || ov;
         end
         if (clr) begin
            m_score = 0; m_pulse = 0; m_may_score = 1;
         end else begin
            m_pulse = rise && m_may_score;
            if (m_pulse) begin
               m_score = (m_score < (1 << SW) - 1) ? m_score + 1 : m_score;
               m_may_score = 0;
            end else if (fs) begin
               m_may_score = 1;
            end
         end
         m_prev_vs = vs;
         m_prev_sc = scored;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("pixel", {7'd0, o_de, o_red, o_green, o_blue}, {7'd0, m_out});
         chk("collision", {31'd0, o_collision}, {31'd0, m_coll});
         chk("score", {{(32-SW){1'b0}}, o_score}, m_score);
         chk("pulse", {31'd0, o_score_pulse}, {31'd0, m_pulse});
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic vs_pulse();
      vs = 1'b1; tick();
      vs = 1'b0; tick();
   endtask

   int pulses;

   initial begin
      rst = 1; de = 0; vs = 0; scored = 0; clr = 0; hit = '0; rgb = '0; bg = '0;
      tick(); tick();
      chk("reset_rgb", {8'd0, o_red, o_green, o_blue}, 32'h0);
      chk("reset_de", {31'd0, o_de}, 32'h0);
      chk("reset_score", {{(32-SW){1'b0}}, o_score}, 32'h0);
      chk("reset_coll", {31'd0, o_collision}, 32'h0);
      rst = 0;

      // Priority: layer 1 wins over layer 2, then background.
      de = 1; hit = 4'b0110; bg = 24'h000080;
      rgb = '0; rgb[24 +: 24] = 24'hFFDB00; rgb[48 +: 24] = 24'h00FF00; rgb[72 +: 24] = 24'h123456;
      tick();
      hit = 4'b0000; tick();
      chk("prio_rgb", {8'd0, o_red, o_green, o_blue}, 32'h00FFDB00);
      chk("prio_de", {31'd0, o_de}, 32'h1);
      de = 0; tick();
      chk("bg_rgb", {8'd0, o_red, o_green, o_blue}, 32'h00000080);

      // Blanking hits are ignored everywhere.
      de = 0; hit = 4'b1111; tick(); tick();
      chk("blank_rgb", {8'd0, o_red, o_green, o_blue}, 32'h0);
      chk("blank_de", {31'd0, o_de}, 32'h0);
      hit = 0; vs_pulse();
      chk("blank_coll", {31'd0, o_collision}, 32'h0);

      // Collision reported after the next frame start, then cleared a frame later.
      de = 1; hit = 4'b0011; tick();
      de = 0; hit = 0; tick();
      vs_pulse();
      chk("coll_set", {31'd0, o_collision}, 32'h1);
      tick(); tick();
      vs_pulse();
      chk("coll_clear", {31'd0, o_collision}, 32'h0);

      // Long scored level counts once; a second rise in the same frame does not count.
      pulses = 0;
      scored = 1;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (o_score_pulse) pulses++;
      end
      chk("score_one", {{(32-SW){1'b0}}, o_score}, 32'd1);
      chk("one_pulse", pulses, 32'd1);
      scored = 0; tick(); scored = 1; tick(); tick();
      chk("same_frame", {{(32-SW){1'b0}}, o_score}, 32'd1);
      scored = 0; tick();
      vs_pulse();
      scored = 1; tick();
      chk("score_two", {{(32-SW){1'b0}}, o_score}, 32'd2);
      scored = 0; tick();

      // Saturation at 15 with a pulse on the 16th rise.
      clr = 1; tick(); clr = 0;
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         vs_pulse();
         scored = 1; tick();
         if (o_score_pulse) pulses++;
         if (i == 15) chk("sat_pulse", {31'd0, o_score_pulse}, 32'h1);
         scored = 0; tick();
      end
      chk("sat_score", {{(32-SW){1'b0}}, o_score}, 32'd15);
      chk("sat_pulses", pulses, 32'd16);

      // Clear overrides a same-cycle increment.
      vs_pulse();
      scored = 1; clr = 1; tick();
      chk("clr_score", {{(32-SW){1'b0}}, o_score}, 32'd0);
      chk("clr_pulse", {31'd0, o_score_pulse}, 32'h0);
      clr = 0; scored = 0; tick();

      // Reset during active video flushes the pipeline, then refills with latency 2.
      de = 1; hit = 4'b0100; tick(); tick();
      rst = 1; tick();
      chk("mid_rst_de", {31'd0, o_de}, 32'h0);
      chk("mid_rst_rgb", {8'd0, o_red, o_green, o_blue}, 32'h0);
      rst = 0; hit = 4'b0001; rgb[0 +: 24] = 24'h123456; tick();
      chk("refill_de0", {31'd0, o_de}, 32'h0);
      de = 0; tick();
      chk("refill_rgb", {8'd0, o_red, o_green, o_blue}, 32'h00123456);
      chk("refill_de1", {31'd0, o_de}, 32'h1);

      // Randomized frames, checked cycle by cycle against the model.
      for (int c = 0; c < 4000; c++) begin
         vs     = (c % 100) < 3;
         de     = ((c % 100) >= 10) && ((c % 100) < 90);
         hit    = NL'($urandom);
         rgb    = {$urandom, $urandom, $urandom};
         bg     = 24'($urandom);
         if ($urandom_range(0, 15) == 0) scored = ~scored;
         clr    = ($urandom_range(0, 199) == 0);
         rst    = ($urandom_range(0, 999) == 0);
         tick();
      end
      rst = 0; clr = 0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
